// File: rtl/scan_pkg.sv
// Shared state encoding and default parameters for the scan sequencer.
// The optional beamformer watchdog is enabled with the SCAN_TIMEOUT_EN macro.
package scan_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_EMIT  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam int DEF_COORD_W     = 16;
   localparam int DEF_OUT_W       = 18;
   localparam int DEF_N_LINES     = 4;
   localparam int DEF_N_DEPTHS    = 256;
   localparam int DEF_TIMEOUT_CYC = 1024;

   // Index width that stays legal when a count is 1.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Line/depth counters and focal-coordinate accumulators for one frame.
// clear loads the frame origin and steps; advance moves to the next depth point.
module scan_addr_gen
   import scan_pkg::*;
#(
   parameter int COORD_W  = DEF_COORD_W,
   parameter int N_LINES  = DEF_N_LINES,
   parameter int N_DEPTHS = DEF_N_DEPTHS,
   parameter int LINE_W   = idx_w(N_LINES),
   parameter int DEPTH_W  = idx_w(N_DEPTHS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               advance,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] x_step,
   input  logic [COORD_W-1:0] z0,
   input  logic [COORD_W-1:0] z_step,
   output logic [LINE_W-1:0]  line,
   output logic [DEPTH_W-1:0] depth,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] z,
   output logic               last
);

   localparam logic [LINE_W-1:0]  LINE_MAX  = LINE_W'(N_LINES - 1);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(N_DEPTHS - 1);

   logic [LINE_W-1:0]  line_q, line_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [COORD_W-1:0] x_q, x_d, z_q, z_d;
   logic [COORD_W-1:0] z0_q, z0_d, xs_q, xs_d, zs_q, zs_d;

   always_comb begin
      line_d  = line_q;
      depth_d = depth_q;
      x_d     = x_q;
      z_d     = z_q;
      z0_d    = z0_q;
      xs_d    = xs_q;
      zs_d    = zs_q;
      if (clear) begin
         line_d  = '0;
         depth_d = '0;
         x_d     = x0;
         z_d     = z0;
         z0_d    = z0;
         xs_d    = x_step;
         zs_d    = z_step;
      end else if (advance) begin
         // Sums wrap naturally at COORD_W bits.
         if (depth_q != DEPTH_MAX) begin
            depth_d = depth_q + DEPTH_W'(1);
            z_d     = z_q + zs_q;
         end else begin
            depth_d = '0;
            z_d     = z0_q;
            line_d  = line_q + LINE_W'(1);
            x_d     = x_q + xs_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         line_q  <= '0;
         depth_q <= '0;
         x_q     <= '0;
         z_q     <= '0;
         z0_q    <= '0;
         xs_q    <= '0;
         zs_q    <= '0;
      end else begin
         line_q  <= line_d;
         depth_q <= depth_d;
         x_q     <= x_d;
         z_q     <= z_d;
         z0_q    <= z0_d;
         xs_q    <= xs_d;
         zs_q    <= zs_d;
      end
   end

   assign line  = line_q;
   assign depth = depth_q;
   assign x     = x_q;
   assign z     = z_q;
   assign last  = (line_q == LINE_MAX) && (depth_q == DEPTH_MAX);

endmodule

// File: rtl/scan_sequencer.sv
// Frame scan sequencer: launches the beamformer per focal point and streams results.
// Define SCAN_TIMEOUT_EN to add a WAIT watchdog that substitutes a zero sample with pix_err.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int  COORD_W     = DEF_COORD_W,
   parameter int  OUT_W       = DEF_OUT_W,
   parameter int  N_LINES     = DEF_N_LINES,
   parameter int  N_DEPTHS    = DEF_N_DEPTHS,
   parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   localparam int LINE_W      = idx_w(N_LINES),
   localparam int DEPTH_W     = idx_w(N_DEPTHS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] x0,
   input  logic [COORD_W-1:0] x_step,
   input  logic [COORD_W-1:0] z0,
   input  logic [COORD_W-1:0] z_step,
   output logic               bf_start,
   output logic [COORD_W-1:0] bf_x_f,
   output logic [COORD_W-1:0] bf_z_f,
   input  logic               bf_valid,
   input  logic [OUT_W-1:0]   bf_data,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [OUT_W-1:0]   pix_data,
   output logic [LINE_W-1:0]  pix_line,
   output logic [DEPTH_W-1:0] pix_depth,
   output logic               pix_last,
   output logic               pix_err,
   output logic               busy,
   output logic               done,
   output logic [2:0]         debug_state
);

   state_e             state_q, state_d;
   logic               bf_start_q, bf_start_d, done_q, done_d, busy_q, busy_d;
   logic               pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
   logic [OUT_W-1:0]   pix_data_q, pix_data_d;
   logic [LINE_W-1:0]  pix_line_q, pix_line_d, cur_line;
   logic [DEPTH_W-1:0] pix_depth_q, pix_depth_d, cur_depth;
   logic               addr_clear, addr_advance, addr_last, capture;

`ifdef SCAN_TIMEOUT_EN
   localparam int               TO_W    = idx_w(TIMEOUT_CYC);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            pix_err_q, pix_err_d, timed_out;
   assign pix_err = pix_err_q;
`else
   assign pix_err = 1'b0;
`endif

   scan_addr_gen #(
      .COORD_W (COORD_W),
      .N_LINES (N_LINES),
      .N_DEPTHS(N_DEPTHS),
      .LINE_W  (LINE_W),
      .DEPTH_W (DEPTH_W)
   ) u_addr (
      .clk    (clk),
      .reset  (reset),
      .clear  (addr_clear),
      .advance(addr_advance),
      .x0     (x0),
      .x_step (x_step),
      .z0     (z0),
      .z_step (z_step),
      .line   (cur_line),
      .depth  (cur_depth),
      .x      (bf_x_f),
      .z      (bf_z_f),
      .last   (addr_last)
   );

   always_comb begin
      state_d      = state_q;
      bf_start_d   = 1'b0;
      done_d       = 1'b0;
      pix_valid_d  = pix_valid_q;
      pix_data_d   = pix_data_q;
      pix_line_d   = pix_line_q;
      pix_depth_d  = pix_depth_q;
      pix_last_d   = pix_last_q;
      addr_clear   = 1'b0;
      addr_advance = 1'b0;
      capture      = 1'b0;
`ifdef SCAN_TIMEOUT_EN
      to_cnt_d     = '0;
      pix_err_d    = pix_err_q;
      timed_out    = 1'b0;
`endif
      case (state_q)
         S_IDLE: if (start) begin
            addr_clear = 1'b1;
            bf_start_d = 1'b1;
            state_d    = S_ISSUE;
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (bf_valid) capture = 1'b1;
`ifdef SCAN_TIMEOUT_EN
            else if (to_cnt_q == TO_LAST) begin
               capture   = 1'b1;
               timed_out = 1'b1;
            end else to_cnt_d = to_cnt_q + TO_W'(1);
`endif
         end
         S_EMIT: if (pix_ready) begin
            pix_valid_d  = 1'b0;
            addr_advance = 1'b1;
            if (pix_last_q) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               bf_start_d = 1'b1;
               state_d    = S_ISSUE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (capture) begin
         pix_valid_d = 1'b1;
         pix_data_d  = bf_data;
         pix_line_d  = cur_line;
         pix_depth_d = cur_depth;
         pix_last_d  = addr_last;
         state_d     = S_EMIT;
`ifdef SCAN_TIMEOUT_EN
         pix_err_d   = timed_out;
         if (timed_out) pix_data_d = '0;
`endif
      end
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         bf_start_q  <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         pix_line_q  <= '0;
         pix_depth_q <= '0;
         pix_last_q  <= 1'b0;
`ifdef SCAN_TIMEOUT_EN
         to_cnt_q    <= '0;
         pix_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bf_start_q  <= bf_start_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
         pix_line_q  <= pix_line_d;
         pix_depth_q <= pix_depth_d;
         pix_last_q  <= pix_last_d;
`ifdef SCAN_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         pix_err_q   <= pix_err_d;
`endif
      end
   end

   assign bf_start    = bf_start_q;
   assign done        = done_q;
   assign busy        = busy_q;
   assign pix_valid   = pix_valid_q;
   assign pix_data    = pix_data_q;
   assign pix_line    = pix_line_q;
   assign pix_depth   = pix_depth_q;
   assign pix_last    = pix_last_q;
   assign debug_state = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: frame model pushes expected focal points,
// a beamformer/monitor process answers bf_start and checks every pixel handshake.
module tb_scan_sequencer;

   localparam int COORD_W = 16, OUT_W = 18, N_LINES = 2, N_DEPTHS = 3, TIMEOUT_CYC = 8;

   logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [15:0] x0 = '0, x_step = '0, z0 = '0, z_step = '0;
   logic        bf_start, bf_valid, pix_valid, pix_last, pix_err, busy, done;
   logic        pix_ready = 1'b0, bf_mdl_valid = 1'b0, stray_valid = 1'b0;
   logic [15:0] bf_x_f, bf_z_f;
   logic [17:0] bf_data = '0, pix_data;
   logic [0:0]  pix_line;
   logic [1:0]  pix_depth;
   logic [2:0]  debug_state;

   assign bf_valid = bf_mdl_valid | stray_valid;
   always #5 clk = ~clk;

   scan_sequencer #(
      .COORD_W(COORD_W), .OUT_W(OUT_W), .N_LINES(N_LINES),
      .N_DEPTHS(N_DEPTHS), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .x0(x0), .x_step(x_step), .z0(z0), .z_step(z_step),
      .bf_start(bf_start), .bf_x_f(bf_x_f), .bf_z_f(bf_z_f),
      .bf_valid(bf_valid), .bf_data(bf_data),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_line(pix_line), .pix_depth(pix_depth), .pix_last(pix_last),
      .pix_err(pix_err), .busy(busy), .done(done), .debug_state(debug_state)
   );

   typedef struct { logic [15:0] x, z; int line, depth; bit last; } focal_t;
   typedef struct { logic [15:0] x, z; logic [17:0] data; int line, depth; bit last, err; int emit_cyc; } pix_t;

   focal_t focal_q[$];
   pix_t   pix_q[$];
   int     errors = 0, checks = 0, frames_done = 0;
   int     bf_lat = 3, stall_idx = -1, stall_len = 0;
   bit     withhold = 0, rand_ready = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Beamformer model + pixel monitor.
   initial begin
      pix_t        cur;
      focal_t      f;
      logic [17:0] hd;
      logic [31:0] hl, hdp, hlast;
      int          cyc = 0, bf_cnt = 0, stall_cnt = 0;
      bit          outstanding = 0, prev_v = 0, exp_done = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            focal_q.delete(); pix_q.delete();
            bf_cnt = 0; bf_mdl_valid = 0; pix_ready = 0;
            outstanding = 0; prev_v = 0; exp_done = 0;
         end else begin
            if (done || exp_done) begin
               chk("done_pulse", 32'(done), 32'(exp_done));
               if (done) chk("done_state", 32'(debug_state), 32'd4);
            end
            if (done) frames_done++;
            exp_done = 0;
            bf_mdl_valid = 0;
            if (bf_cnt > 0) begin
               bf_cnt--;
               if (bf_cnt == 0) bf_mdl_valid = 1;
            end
            if (bf_start) begin
               chk("bf_start_while_outstanding", 32'(outstanding), 32'd0);
               chk("issue_state", 32'(debug_state), 32'd1);
               if (focal_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL bf_start_unexpected: got bf_start, expected none");
               end else begin
                  f = focal_q.pop_front();
                  chk("bf_x_f", 32'(bf_x_f), 32'(f.x));
                  chk("bf_z_f", 32'(bf_z_f), 32'(f.z));
                  bf_data      = 18'($urandom);
                  cur.x        = f.x;
                  cur.z        = f.z;
                  cur.data     = withhold ? 18'd0 : bf_data;
                  cur.line     = f.line;
                  cur.depth    = f.depth;
                  cur.last     = f.last;
                  cur.err      = withhold;
                  cur.emit_cyc = cyc + (withhold ? TIMEOUT_CYC : bf_lat) + 1;
                  pix_q.push_back(cur);
                  bf_cnt = withhold ? 0 : bf_lat;
               end
               outstanding = 1;
            end
            if (prev_v && !pix_valid) chk("valid_dropped_before_ready", 32'(pix_valid), 32'd1);
            if (pix_valid) begin
               if (!prev_v && pix_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL pix_unexpected: got pix_valid, expected none");
                  pix_ready = 1;
               end else begin
                  cur = pix_q[0];
                  if (!prev_v) begin
                     stall_cnt = 0;
                     chk("emit_cycle", 32'(cyc), 32'(cur.emit_cyc));
                     chk("emit_state", 32'(debug_state), 32'd3);
                     hd = pix_data; hl = 32'(pix_line); hdp = 32'(pix_depth); hlast = 32'(pix_last);
                  end else begin
                     chk("hold_data", 32'(pix_data), 32'(hd));
                     chk("hold_line", 32'(pix_line), hl);
                     chk("hold_depth", 32'(pix_depth), hdp);
                     chk("hold_last", 32'(pix_last), hlast);
                  end
                  if (cur.line * N_DEPTHS + cur.depth == stall_idx && stall_cnt < stall_len) begin
                     pix_ready = 0;
                     stall_cnt++;
                  end else pix_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
                  if (pix_ready) begin
                     void'(pix_q.pop_front());
                     chk("pix_data", 32'(pix_data), 32'(cur.data));
                     chk("pix_line", 32'(pix_line), 32'(cur.line));
                     chk("pix_depth", 32'(pix_depth), 32'(cur.depth));
                     chk("pix_last", 32'(pix_last), 32'(cur.last));
                     chk("pix_err", 32'(pix_err), 32'(cur.err));
                     chk("focal_x_held", 32'(bf_x_f), 32'(cur.x));
                     chk("focal_z_held", 32'(bf_z_f), 32'(cur.z));
                     chk("busy_in_frame", 32'(busy), 32'd1);
                     outstanding = 0;
                     prev_v = 0;
                     if (cur.last) exp_done = 1;
                  end else prev_v = 1;
               end
            end else begin
               prev_v = 0;
               pix_ready = 0;
            end
         end
      end
   end

   task automatic push_frame(input logic [15:0] ax0, axs, az0, azs);
      focal_t f;
      for (int l = 0; l < N_LINES; l++)
         for (int d = 0; d < N_DEPTHS; d++) begin
            f.x = ax0 + 16'(l) * axs;
            f.z = az0 + 16'(d) * azs;
            f.line = l;
            f.depth = d;
            f.last = (l == N_LINES - 1) && (d == N_DEPTHS - 1);
            focal_q.push_back(f);
         end
   endtask

   task automatic launch(input logic [15:0] ax0, axs, az0, azs, input bit hold);
      @(posedge clk); #1;
      x0 = ax0; x_step = axs; z0 = az0; z_step = azs; start = 1;
      @(posedge clk); #1;
      if (!hold) start = 0;
      // Scramble config after acceptance: the DUT must use its latched copy.
      x0 = 16'($urandom); x_step = 16'($urandom); z0 = 16'($urandom); z_step = 16'($urandom);
   endtask

   task automatic run_frame(input logic [15:0] ax0, axs, az0, azs, input bit hold);
      int base, n;
      push_frame(ax0, axs, az0, azs);
      launch(ax0, axs, az0, azs, hold);
      base = frames_done;
      n = 0;
      while (frames_done == base && n < 4000) begin
         @(posedge clk); #1;
         n++;
      end
      start = 0;
      if (frames_done == base) begin
         checks++; errors++;
         $display("FAIL frame_timeout: got no done in %0d cycles, expected done", n);
      end
      chk("frame_items_left", 32'(pix_q.size() + focal_q.size()), 32'd0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_bf_start"}, 32'(bf_start), 0);
      chk({tag, "_bf_x_f"}, 32'(bf_x_f), 0);
      chk({tag, "_bf_z_f"}, 32'(bf_z_f), 0);
      chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
      chk({tag, "_pix_data"}, 32'(pix_data), 0);
      chk({tag, "_pix_line"}, 32'(pix_line), 0);
      chk({tag, "_pix_depth"}, 32'(pix_depth), 0);
      chk({tag, "_pix_last"}, 32'(pix_last), 0);
      chk({tag, "_pix_err"}, 32'(pix_err), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_state"}, 32'(debug_state), 0);
   endtask

   initial begin
      int n, cnt;
      // Reset wins over a simultaneous start.
      reset = 1; start = 1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      start = 0; reset = 0;

      run_frame(16'd10, 16'd5, 16'd0, 16'd4, 0);

      stall_idx = 1; stall_len = 5;
      run_frame(16'd10, 16'd5, 16'd0, 16'd4, 0);
      stall_idx = -1; stall_len = 0;

      run_frame(16'hFFFE, 16'd3, 16'd0, 16'd4, 0);

      // Reset while waiting on pixel 4, then a clean restart.
      push_frame(16'd10, 16'd5, 16'd0, 16'd4);
      launch(16'd10, 16'd5, 16'd0, 16'd4, 0);
      n = 0; cnt = 0;
      while (cnt < 4 && n < 500) begin
         if (bf_start) cnt++;
         if (cnt < 4) begin
            @(posedge clk); #1;
            n++;
         end
      end
      chk("reached_pixel4", 32'(cnt), 32'd4);
      @(posedge clk); #1;
      chk("wait_before_reset", 32'(debug_state), 32'd2);
      reset = 1;
      @(posedge clk); #1;
      check_zero("midframe");
      reset = 0;
      run_frame(16'd10, 16'd5, 16'd0, 16'd4, 0);

      // start held through the whole frame, then a stray bf_valid in IDLE.
      run_frame(16'd7, 16'd2, 16'd100, 16'd9, 1);
      repeat (2) @(posedge clk);
      #1;
      stray_valid = 1;
      @(posedge clk); #1;
      stray_valid = 0;
      repeat (6) begin
         @(posedge clk); #1;
         chk("idle_busy", 32'(busy), 0);
         chk("idle_pix_valid", 32'(pix_valid), 0);
         chk("idle_bf_start", 32'(bf_start), 0);
      end

`ifdef SCAN_TIMEOUT_EN
      withhold = 1;
      run_frame(16'd3, 16'd1, 16'd2, 16'd1, 0);
      withhold = 0;
`endif

      rand_ready = 1;
      for (int i = 0; i < 8; i++) begin
         bf_lat = $urandom_range(6, 1);
         run_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0);
      end
      rand_ready = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, expected finish before 500000");
      $fatal(1);
   end

endmodule

// File: doc/scan_sequencer.md
SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 SHALL have parameter COORD_W, default 16: focal-coordinate width.
REQ-002 SHALL have parameter OUT_W, default 18: beamformed sample width.
REQ-003 SHALL have parameter N_LINES, default 4: scan lines per frame.
REQ-004 SHALL have parameter N_DEPTHS, default 256: depth points per line.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1024: beamformer watchdog limit, used only with SCAN_TIMEOUT_EN.
REQ-006 Ports SHALL be as follows; one clock, and reset is synchronous and active-high:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  frame request; sampled only in IDLE.
- x0, x_step, z0, z_step  in  COORD_W each  frame origin and increments; latched on accepted start.
- bf_start  out  1  one-cycle beamformer launch pulse.
- bf_x_f, bf_z_f  out  COORD_W each  current focal point.
- bf_valid  in  1  beamformer result strobe.
- bf_data  in  OUT_W  beamformer result.
- pix_valid  out  1  output sample valid.
- pix_ready  in  1  downstream accept.
- pix_data  out  OUT_W  captured sample.
- pix_line  out  clog2(N_LINES)  line index of pix_data.
- pix_depth  out  clog2(N_DEPTHS)  depth index of pix_data.
- pix_last  out  1  final sample of frame.
- pix_err  out  1  sample substituted after timeout (tied 0 without the macro).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at frame end.
- debug_state  out  3  encoded FSM state.

Function
REQ-007 FSM states and encodings SHALL be IDLE=0, ISSUE=1, WAIT=2, EMIT=3, DONE=4.
REQ-008 IDLE with start=1 SHALL latch config, set line=0, depth=0, x=x0, z=z0, and go to ISSUE; start in other states SHALL be ignored.
REQ-009 ISSUE SHALL assert bf_start for exactly one cycle, then go to WAIT; bf_start SHALL occur 1 cycle after the accepted start.
REQ-010 bf_x_f/bf_z_f SHALL hold stable from ISSUE until the EMIT handshake.
REQ-011 WAIT SHALL capture bf_data, line and depth into the pix registers on bf_valid=1 and go to EMIT; bf_valid in any other state SHALL be ignored.
REQ-012 EMIT SHALL hold pix_valid=1 and the pix fields stable until pix_ready=1; pix_ready=0 SHALL stall indefinitely.
REQ-013 On the EMIT handshake: if depth<N_DEPTHS-1, then depth+=1 and z+=z_step; else depth=0, z=z0, line+=1, x+=x_step.
REQ-014 Coordinate adds SHALL wrap modulo 2^COORD_W.
REQ-015 pix_last SHALL be 1 only when line=N_LINES-1 and depth=N_DEPTHS-1; its handshake SHALL go to DONE, otherwise to ISSUE.
REQ-016 DONE SHALL pulse done=1 for one cycle and return to IDLE; start in the DONE cycle SHALL be ignored.
REQ-017 A frame SHALL produce exactly N_LINES*N_DEPTHS pixel handshakes, line-major, depth ascending.

Reset
REQ-018 reset=1 at any clock edge, mid-frame included, SHALL force IDLE, clear the counters, and drive all outputs to 0 on the next cycle; reset SHALL take priority over start.

Configuration
REQ-019 With SCAN_TIMEOUT_EN defined, a counter SHALL run in WAIT; on reaching TIMEOUT_CYC cycles without bf_valid, it SHALL enter EMIT with pix_data=0 and pix_err=1.
REQ-020 Without SCAN_TIMEOUT_EN, the counter SHALL be absent, WAIT SHALL wait forever, and pix_err SHALL be 0.

Structure
REQ-021 The package scan_pkg SHALL hold the state enum/encodings and the default parameter constants.
REQ-022 One sub-module, scan_addr_gen, SHALL hold the line/depth counters and coordinate accumulators, with clear and advance inputs.

Verification
REQ-023 N_LINES=2, N_DEPTHS=3, x0=10, x_step=5, z0=0, z_step=4, model bf_valid 3 cycles after bf_start, pix_ready=1 -> focal points (10,0),(10,4),(10,8),(15,0),(15,4),(15,8); 6 pixels; pix_last on the 6th; done one cycle later.
REQ-024 Same setup with pix_ready=0 for 5 cycles on pixel 2 -> pix_data/line/depth held; no new bf_start until the handshake.
REQ-025 x0=16'hFFFE, x_step=3 -> second line bf_x_f=16'h0001.
REQ-026 Reset asserted in WAIT of pixel 4 -> next cycle IDLE with all outputs 0; a new start restarts at line 0, depth 0.
REQ-027 SCAN_TIMEOUT_EN, TIMEOUT_CYC=8, bf_valid withheld -> EMIT after 8 WAIT cycles with pix_data=0, pix_err=1; the frame continues.
REQ-028 start held high through a frame, and bf_valid pulsed while in IDLE -> one frame only; the stray bf_valid produces no pixel.
